// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS/TERC4 encoder: period modes, fixed code tables
// and the S1 pipeline record.
package tmds_pkg;

  localparam logic [2:0] MODE_CTRL  = 3'd0;
  localparam logic [2:0] MODE_VGB   = 3'd1;
  localparam logic [2:0] MODE_VIDEO = 3'd2;
  localparam logic [2:0] MODE_DGB   = 3'd3;
  localparam logic [2:0] MODE_TERC4 = 3'd4;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;

  localparam logic [9:0] CTRL_CODE [4] = '{
    CTRL_00, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b0011100101, 10'b1100011001, 10'b0010011101, 10'b0100011101,
    10'b1000111010, 10'b0111100010, 10'b0111000110, 10'b0011110010,
    10'b0011001101, 10'b1001110010, 10'b0011100110, 10'b0110001101,
    10'b0111000101, 10'b1000111001, 10'b1100011010, 10'b1100001101
  };

  localparam logic [9:0] GB_A = 10'b0011001101;
  localparam logic [9:0] GB_B = 10'b1100110010;

  // Everything S2 needs about one lane's symbol, captured in S1.
  typedef struct packed {
    logic [2:0] mode;
    logic [8:0] qm;
    logic [3:0] n1;
    logic [1:0] ctrl;
    logic [3:0] aux;
  } s1_t;

  function automatic logic [3:0] n1_8(input logic [7:0] v);
    n1_8 = '0;
    for (int i = 0; i < 8; i++) n1_8 += {3'b000, v[i]};
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS/TERC4 lane: S1 transition-minimisation stage and S2 symbol/disparity
// stage. LANE selects the guard-band pattern for this lane position.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ce,
  input  logic [2:0]        mode,
  input  logic [7:0]        din,
  input  logic [1:0]        ctrl,
  input  logic [3:0]        aux,
  output logic [9:0]        sym,
  output logic signed [4:0] cnt,
  output logic              illegal
);

  s1_t               s1_d, s1_q;
  logic [9:0]        sym_d, sym_q;
  logic signed [4:0] cnt_d, cnt_q;

  always_comb begin : s1_comb
    logic       acc;
    logic       xnor_sel;
    logic [3:0] ones;
    ones     = n1_8(din);
    xnor_sel = (ones > 4'd4) || (ones == 4'd4 && !din[0]);
    s1_d      = '0;
    s1_d.mode = mode;
    s1_d.ctrl = ctrl;
    s1_d.aux  = aux;
    acc       = din[0];
    s1_d.qm[0] = acc;
    for (int i = 1; i < 8; i++) begin
      acc        = xnor_sel ? ~(acc ^ din[i]) : (acc ^ din[i]);
      s1_d.qm[i] = acc;
    end
    s1_d.qm[8] = ~xnor_sel;
    s1_d.n1    = n1_8(s1_d.qm[7:0]);
  end

  always_comb begin : s2_comb
    logic signed [4:0] n1s;
    logic signed [4:0] n0s;
    logic              q8;
    n1s = signed'({1'b0, s1_q.n1});
    n0s = 5'sd8 - n1s;
    q8  = s1_q.qm[8];
    // NOTE: every output gets a default first so no path can infer a latch;
    // illegal modes fall through to the CTRL encoding with cnt cleared.
    sym_d = CTRL_CODE[s1_q.ctrl];
    cnt_d = 5'sd0;
    case (s1_q.mode)
      MODE_VGB:   sym_d = (LANE % 3 == 1) ? GB_B : GB_A;
      MODE_DGB:   sym_d = (LANE % 3 == 0) ? TERC4_CODE[{2'b11, s1_q.ctrl}] : GB_B;
      MODE_TERC4: sym_d = TERC4_CODE[s1_q.aux];
      MODE_VIDEO: begin
        if (cnt_q == 5'sd0 || n1s == n0s) begin
          sym_d = {~q8, q8, q8 ? s1_q.qm[7:0] : ~s1_q.qm[7:0]};
          cnt_d = q8 ? cnt_q + n1s - n0s : cnt_q + n0s - n1s;
        end else if ((cnt_q > 5'sd0 && n1s > n0s) || (cnt_q < 5'sd0 && n0s > n1s)) begin
          sym_d = {1'b1, q8, ~s1_q.qm[7:0]};
          cnt_d = cnt_q + (q8 ? 5'sd2 : 5'sd0) + n0s - n1s;
        end else begin
          sym_d = {1'b0, q8, s1_q.qm[7:0]};
          cnt_d = cnt_q - (q8 ? 5'sd0 : 5'sd2) + n1s - n0s;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q  <= '{mode: MODE_CTRL, default: '0};
      sym_q <= CTRL_00;
      cnt_q <= 5'sd0;
    end else if (ce) begin
      s1_q  <= s1_d;
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym     = sym_q;
  assign cnt     = cnt_q;
  assign illegal = (s1_q.mode > MODE_TERC4);

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS/TERC4 encoder: NUM_CH lockstep lanes, PIPE extra output
// stages and a sticky illegal-mode flag, all gated by ce.
module tmds_encoder_mc
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int PIPE   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ce,
  input  logic [2:0]            mode,
  input  logic [8*NUM_CH-1:0]   din,
  input  logic [2*NUM_CH-1:0]   ctrl,
  input  logic [4*NUM_CH-1:0]   aux,
  output logic [10*NUM_CH-1:0]  dout,
  output logic [5*NUM_CH-1:0]   disp,
  output logic                  mode_err
);

  localparam int DW = 10 * NUM_CH;
  localparam int CW = 5 * NUM_CH;

  logic [DW-1:0]     core_dout;
  logic [CW-1:0]     core_disp;
  logic [NUM_CH-1:0] lane_illegal;
  logic              mode_err_d, mode_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tmds_lane #(.LANE(i)) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .ce      (ce),
      .mode    (mode),
      .din     (din[8*i +: 8]),
      .ctrl    (ctrl[2*i +: 2]),
      .aux     (aux[4*i +: 4]),
      .sym     (core_dout[10*i +: 10]),
      .cnt     (core_disp[5*i +: 5]),
      .illegal (lane_illegal[i])
    );
  end

  // All lanes see the same mode, so any lane's flag marks the symbol entering S2.
  always_comb mode_err_d = mode_err_q | (|lane_illegal);

  always_ff @(posedge clk) begin
    if (!resetn)  mode_err_q <= 1'b0;
    else if (ce)  mode_err_q <= mode_err_d;
  end

  assign mode_err = mode_err_q;

  if (PIPE == 0) begin : g_nopipe
    assign dout = core_dout;
    assign disp = core_disp;
  end else begin : g_pipe
    logic [DW-1:0] dout_pipe_d [PIPE];
    logic [DW-1:0] dout_pipe_q [PIPE];
    logic [CW-1:0] disp_pipe_d [PIPE];
    logic [CW-1:0] disp_pipe_q [PIPE];

    always_comb begin
      dout_pipe_d[0] = core_dout;
      disp_pipe_d[0] = core_disp;
      for (int s = 1; s < PIPE; s++) begin
        dout_pipe_d[s] = dout_pipe_q[s-1];
        disp_pipe_d[s] = disp_pipe_q[s-1];
      end
    end

    // NOTE: the delay stages are reset like any other flop (not treated as
    // memory) so dout shows the CTRL/00 idle code straight out of reset.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int s = 0; s < PIPE; s++) begin
          dout_pipe_q[s] <= {NUM_CH{CTRL_00}};
          disp_pipe_q[s] <= '0;
        end
      end else if (ce) begin
        dout_pipe_q <= dout_pipe_d;
        disp_pipe_q <= disp_pipe_d;
      end
    end

    assign dout = dout_pipe_q[PIPE-1];
    assign disp = disp_pipe_q[PIPE-1];
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Bench for tmds_encoder_mc: PIPE=0 and PIPE=2 instances on shared stimulus,
// compared every cycle against a symbol-level reference model.
module tb_tmds_encoder_mc;

  localparam int NCH = 3;

  logic              clk;
  logic              resetn;
  logic              ce;
  logic [2:0]        mode;
  logic [8*NCH-1:0]  din;
  logic [2*NCH-1:0]  ctrl;
  logic [4*NCH-1:0]  aux;
  logic [10*NCH-1:0] dout0, dout2;
  logic [5*NCH-1:0]  disp0, disp2;
  logic              err0, err2;

  tmds_encoder_mc #(.NUM_CH(NCH), .PIPE(0)) dut0 (
    .clk(clk), .resetn(resetn), .ce(ce), .mode(mode), .din(din), .ctrl(ctrl),
    .aux(aux), .dout(dout0), .disp(disp0), .mode_err(err0)
  );

  tmds_encoder_mc #(.NUM_CH(NCH), .PIPE(2)) dut2 (
    .clk(clk), .resetn(resetn), .ce(ce), .mode(mode), .din(din), .ctrl(ctrl),
    .aux(aux), .dout(dout2), .disp(disp2), .mode_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] ctrl_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc_tbl [16] = '{
    10'b0011100101, 10'b1100011001, 10'b0010011101, 10'b0100011101,
    10'b1000111010, 10'b0111100010, 10'b0111000110, 10'b0011110010,
    10'b0011001101, 10'b1001110010, 10'b0011100110, 10'b0110001101,
    10'b0111000101, 10'b1000111001, 10'b1100011010, 10'b1100001101
  };
  localparam logic [9:0] GBA = 10'b0011001101;
  localparam logic [9:0] GBB = 10'b1100110010;
  localparam logic [29:0] RST_DOUT = {3{10'b1101010100}};

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // DVI 1.0 video encoding written straight from the algorithm, integer arithmetic.
  function automatic logic [9:0] enc_video(input logic [7:0] d, inout int cnt);
    int         n1, a, z, q8;
    bit         use_xnor;
    logic [8:0] qm;
    logic [9:0] o;
    n1       = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    q8    = qm[8] ? 1 : 0;
    a     = $countones(qm[7:0]);
    z     = 8 - a;
    if (cnt == 0 || a == z) begin
      o   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt = cnt + ((q8 == 1) ? (a - z) : (z - a));
    end else if ((cnt > 0 && a > z) || (cnt < 0 && z > a)) begin
      o   = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + 2 * q8 + z - a;
    end else begin
      o   = {1'b0, qm[8], qm[7:0]};
      cnt = cnt - 2 * (1 - q8) + a - z;
    end
    return o;
  endfunction

  // History of encoded symbols, newest at index 0, advanced once per ce edge.
  logic [29:0] dout_h [4];
  logic [14:0] disp_h [4];
  bit          ill_h  [4];
  int          disp_m [NCH];
  bit          err_m;

  always @(posedge clk) begin : model
    logic [9:0] s;
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        dout_h[k] = RST_DOUT;
        disp_h[k] = '0;
        ill_h[k]  = 0;
      end
      for (int i = 0; i < NCH; i++) disp_m[i] = 0;
      err_m = 0;
    end else if (ce) begin
      for (int k = 3; k > 0; k--) begin
        dout_h[k] = dout_h[k-1];
        disp_h[k] = disp_h[k-1];
        ill_h[k]  = ill_h[k-1];
      end
      ill_h[0] = (mode > 3'd4);
      for (int i = 0; i < NCH; i++) begin
        case (mode)
          3'd1: s = (i % 3 == 1) ? GBB : GBA;
          3'd2: s = enc_video(din[8*i +: 8], disp_m[i]);
          3'd3: s = (i % 3 == 0) ? terc_tbl[{2'b11, ctrl[2*i +: 2]}] : GBB;
          3'd4: s = terc_tbl[aux[4*i +: 4]];
          default: s = ctrl_tbl[ctrl[2*i +: 2]];
        endcase
        if (mode != 3'd2) disp_m[i] = 0;
        dout_h[0][10*i +: 10] = s;
        disp_h[0][5*i +: 5]   = 5'(disp_m[i]);
      end
      err_m = err_m | ill_h[1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout_pipe0", dout0, dout_h[1]);
      check("disp_pipe0", disp0, disp_h[1]);
      check("moderr_pipe0", err0, err_m);
      check("dout_pipe2", dout2, dout_h[3]);
      check("disp_pipe2", disp2, disp_h[3]);
      check("moderr_pipe2", err2, err_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input bit allow_illegal);
    int r;
    r = allow_illegal ? $urandom_range(0, 11) : $urandom_range(0, 8);
    if (r <= 4)      mode = 3'd2;
    else if (r <= 8) mode = 3'(r - 5 + (r == 5 ? 0 : 0)) == 3'd0 ? 3'd0 : ((r == 6) ? 3'd1 : ((r == 7) ? 3'd3 : 3'd4));
    else             mode = 3'(r - 4);
    din  = 24'($urandom);
    ctrl = 6'($urandom);
    aux  = 12'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dout0"}, dout0, RST_DOUT);
    check({tag, "_disp0"}, disp0, 15'd0);
    check({tag, "_err0"}, err0, 1'b0);
    check({tag, "_dout2"}, dout2, RST_DOUT);
    check({tag, "_disp2"}, disp2, 15'd0);
  endtask

  initial begin
    resetn = 1'b0; ce = 1'b1; mode = 3'd0; din = '0; ctrl = '0; aux = '0;

    // Reset with ce high, then with ce low after real traffic.
    tick(); chk_en = 1;
    tick(); tick();
    check_reset_vals("rst_ce1");
    resetn = 1'b1;
    for (int n = 0; n < 6; n++) begin mode = 3'd2; din = 24'($urandom); tick(); end
    resetn = 1'b0; ce = 1'b0;
    tick(); tick(); tick();
    check_reset_vals("rst_ce0");
    resetn = 1'b1; ce = 1'b1;

    // Video zeros: disparity walk -8, +2, -6.
    mode = 3'd2; din = '0;
    tick(); tick();
    check("vid0_sym1", dout0[9:0], 10'h100); check("vid0_disp1", disp0[4:0], 5'h18);
    tick();
    check("vid0_sym2", dout0[9:0], 10'h3FF); check("vid0_disp2", disp0[4:0], 5'h02);
    tick();
    check("vid0_sym3", dout0[9:0], 10'h100); check("vid0_disp3", disp0[4:0], 5'h1A);

    // Control codes per lane, then video guard band.
    mode = 3'd0; ctrl = {2'b11, 2'b10, 2'b01};
    tick(); tick();
    check("ctrl_lanes", dout0, {10'b1010101011, 10'b0101010100, 10'b0010101011});
    check("ctrl_disp", disp0, 15'd0);
    mode = 3'd1;
    tick(); tick();
    check("vgb_lanes", dout0, {GBA, GBB, GBA});

    // TERC4 sweep on lane 1, then data-island guard band.
    mode = 3'd4;
    for (int a = 0; a < 16; a++) begin
      aux = {4'h0, 4'(a), 4'h0};
      tick();
      if (a > 0) check("terc4_sweep", dout0[19:10], terc_tbl[a-1]);
    end
    tick();
    check("terc4_last", dout0[19:10], 10'b1100001101);
    mode = 3'd3; ctrl = {2'b00, 2'b00, 2'b10};
    tick(); tick();
    check("dgb_lanes", dout0, {GBB, GBB, 10'b1100011010});

    // ce gating with PIPE=2: marker needs exactly four ce-high edges.
    mode = 3'd0; ctrl = '0;
    repeat (4) tick();
    mode = 3'd4; aux = 12'h555; tick();
    aux = '0; ce = 1'b0; tick();
    ce = 1'b1; tick(); tick();
    ce = 1'b0; tick();
    check("ce_not_yet", dout2, RST_DOUT);
    ce = 1'b1; tick();
    check("ce_marker", dout2, {3{10'b0111100010}});
    for (int n = 0; n < 24; n++) begin
      rand_inputs(0);
      ce = (n % 6 == 1 || n % 6 == 4) ? 1'b0 : 1'b1;
      tick();
    end

    // Random legal traffic.
    for (int n = 0; n < 300; n++) begin
      rand_inputs(0);
      ce = ($urandom_range(0, 4) != 0);
      tick();
    end

    // Illegal mode mid-video.
    ce = 1'b1;
    for (int n = 0; n < 4; n++) begin mode = 3'd2; din = 24'($urandom); tick(); end
    mode = 3'd6; ctrl = {2'b11, 2'b10, 2'b01};
    tick();
    check("ill_err_early", err0, 1'b0);
    mode = 3'd2;
    tick();
    check("ill_ctrl_sym", dout0, {10'b1010101011, 10'b0101010100, 10'b0010101011});
    check("ill_disp", disp0, 15'd0);
    check("ill_err_set", err0, 1'b1);
    for (int n = 0; n < 10; n++) begin rand_inputs(0); tick(); end
    check("ill_err_sticky0", err0, 1'b1);
    check("ill_err_sticky2", err2, 1'b1);
    for (int n = 0; n < 100; n++) begin
      rand_inputs(1);
      ce = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset pulse mid-stream, overriding ce=0.
    resetn = 1'b0; ce = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    check("rst_mid_err2", err2, 1'b0);
    resetn = 1'b1; ce = 1'b1;
    for (int n = 0; n < 20; n++) begin rand_inputs(0); tick(); end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
